// File: rtl/keypad_entry_buffer_if.sv
// Keypad entry bus: key strobes in, presented code and status out.
//   key_valid/key_code      : one-cycle key strobe and its code
//   digit_a..digit_e        : presented code, 4'hF unless entry_valid
//   entry_valid             : complete code is being presented
//   digit_count             : digits currently held (0-5)
//   timeout                 : one-cycle pulse when a partial entry expires
// master = keypad side, slave = entry buffer.
interface keypad_entry_buffer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_a;
    logic [3:0] digit_b;
    logic [3:0] digit_c;
    logic [3:0] digit_d;
    logic [3:0] digit_e;
    logic       entry_valid;
    logic [2:0] digit_count;
    logic       timeout;

    modport master (
        output key_valid,
        output key_code,
        input  digit_a,
        input  digit_b,
        input  digit_c,
        input  digit_d,
        input  digit_e,
        input  entry_valid,
        input  digit_count,
        input  timeout
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output digit_a,
        output digit_b,
        output digit_c,
        output digit_d,
        output digit_e,
        output entry_valid,
        output digit_count,
        output timeout
    );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer for the five-digit combination lock.
// Collects key strobes into five digit slots with backspace, clear and an
// inter-key timeout, then presents the completed code for HOLD_CYCLES cycles.
// Ports:
//   clk : rising-edge system clock
//   rst : asynchronous active-high reset
//   bus : keypad_entry_buffer_if.slave (key strobe in, code/status out)
module keypad_entry_buffer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned HOLD_CYCLES    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_entry_buffer_if.slave  bus
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned NUM_DIGITS = 5;
    localparam logic [3:0]  BLANK   = 4'hF;
    localparam logic [3:0]  KEY_BKSP  = 4'hE;
    localparam logic [3:0]  KEY_CLEAR = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          slot [NUM_DIGITS];
    logic [3:0]          dout [NUM_DIGITS];
    logic [2:0]          count;
    logic [TIMER_W-1:0]  timer;
    logic [HOLD_W-1:0]   hold;
    logic                entry_valid_q;
    logic                timeout_q;

    // Key decode; codes 0xA-0xD decode to nothing and are ignored.
    logic is_digit_c;
    logic is_bksp_c;
    logic is_clear_c;
    logic expire_c;

    assign is_digit_c = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_bksp_c  = bus.key_valid && (bus.key_code == KEY_BKSP);
    assign is_clear_c = bus.key_valid && (bus.key_code == KEY_CLEAR);
    // This idle edge would bring the timer to TIMEOUT_CYCLES-1.
    assign expire_c   = (timer == TIMER_W'(TIMEOUT_CYCLES - 2));

    // Entry state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 3'd0;
            timer         <= '0;
            hold          <= '0;
            entry_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                slot[i] <= BLANK;
                dout[i] <= BLANK;
            end
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (is_digit_c) begin
                        slot[0] <= bus.key_code;
                        count   <= 3'd1;
                        state   <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (is_digit_c) begin
                        slot[count] <= bus.key_code;
                        count       <= count + 3'd1;
                        timer       <= '0;
                        if (count == 3'd4) begin
                            // Fifth digit: latch the full code into the output registers.
                            state         <= PRESENT;
                            hold          <= '0;
                            entry_valid_q <= 1'b1;
                            for (int i = 0; i < 4; i++) begin
                                dout[i] <= slot[i];
                            end
                            dout[4] <= bus.key_code;
                        end
                    end else if (is_bksp_c) begin
                        slot[count - 3'd1] <= BLANK;
                        count              <= count - 3'd1;
                        timer              <= '0;
                        if (count == 3'd1) begin
                            state <= IDLE;
                        end
                    end else if (is_clear_c) begin
                        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                            slot[i] <= BLANK;
                        end
                        count <= 3'd0;
                        timer <= '0;
                        state <= IDLE;
                    end else if (expire_c) begin
                        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                            slot[i] <= BLANK;
                        end
                        count     <= 3'd0;
                        timer     <= '0;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                PRESENT: begin
                    // Keys are ignored for the whole window, including the exit edge.
                    timer <= '0;
                    if (hold == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state         <= IDLE;
                        count         <= 3'd0;
                        entry_valid_q <= 1'b0;
                        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                            slot[i] <= BLANK;
                            dout[i] <= BLANK;
                        end
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= 3'd0;
                    timer <= '0;
                end
            endcase
        end
    end

    assign bus.digit_a     = dout[0];
    assign bus.digit_b     = dout[1];
    assign bus.digit_c     = dout[2];
    assign bus.digit_d     = dout[3];
    assign bus.digit_e     = dout[4];
    assign bus.entry_valid = entry_valid_q;
    assign bus.digit_count = count;
    assign bus.timeout     = timeout_q;

endmodule

// File: doc/keypad_entry_buffer.md
Name: keypad_entry_buffer

Overview:
- Upstream stage of the five-digit combination lock.
- Collects single-cycle keypad strobes into five digit registers, supports backspace, clear and an inter-key timeout.
- After the fifth digit it presents the complete code on digit_a..digit_e for a fixed hold window with entry_valid high, then self-clears.
- Outside that window all digit outputs read 4'hF, a value no password digit uses, so the combinational comparator downstream never matches a partial entry.

Parameters:
TIMEOUT_CYCLES, 50000000, clk cycles allowed between accepted keys before a partial entry is discarded (>=2)
HOLD_CYCLES, 4, cycles the completed code and entry_valid are presented (>=1)

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe: key_code is valid this cycle
key_code  input  4  0x0-0x9 digit, 0xE backspace, 0xF clear, 0xA-0xD ignored
digit_a  output  4  first entered digit; 4'hF unless entry_valid
digit_b  output  4  second digit; 4'hF unless entry_valid
digit_c  output  4  third digit; 4'hF unless entry_valid
digit_d  output  4  fourth digit; 4'hF unless entry_valid
digit_e  output  4  fifth digit; 4'hF unless entry_valid
entry_valid  output  1  high while the complete code is presented
digit_count  output  3  digits currently held, 0-5
timeout  output  1  one-cycle pulse when a partial entry expires

Behaviour:
- Reset is asynchronous and active-high:
  - state IDLE, digit_count 0, internal digits 4'hF.
  - All digit outputs 4'hF, entry_valid 0, timeout 0, timer 0.
  - Reset mid-entry or mid-PRESENT discards everything immediately.
- All outputs are registered. A key is sampled on the clk rising edge where key_valid=1; its effect is visible the following cycle.
- State IDLE (count 0):
  - Digit: store in slot a, count=1, go to COLLECT, timer=0.
  - Backspace, clear and 0xA-0xD: ignored.
- State COLLECT (count 1-4):
  - Digit: store in slot [count], count+1, timer=0.
  - If that digit makes count 5: go to PRESENT.
  - Backspace: slot [count-1] reset to 4'hF, count-1, timer=0. Count reaching 0 goes to IDLE.
  - Clear: all slots 4'hF, count 0, go to IDLE. No timeout pulse.
  - 0xA-0xD: ignored and do not reload the timer.
  - With no accepted key, timer increments every cycle. When timer reaches TIMEOUT_CYCLES-1:
    - Slots are cleared, count 0, go to IDLE.
    - timeout pulses high for exactly one cycle.
  - Simultaneous key_valid (digit, backspace or clear) and timer expiry: the key wins, normal key action applies, no timeout pulse.
- State PRESENT:
  - Entered the cycle after the 5th digit edge.
  - entry_valid=1 and digit outputs show slots a-e for exactly HOLD_CYCLES cycles; digit_count=5.
  - All key_valid strobes are ignored, including clear and backspace.
  - After HOLD_CYCLES, in one edge: go to IDLE, entry_valid 0, outputs 4'hF, slots 4'hF, count 0.
  - A digit strobed on that same exit edge is ignored. Entry restarts on the next strobe.
- Digit outputs = slot value when entry_valid=1, else 4'hF. They are registered together with entry_valid, so there is no glitch.
- The timer runs only in COLLECT and is held at 0 elsewhere. It is wide enough for TIMEOUT_CYCLES, with no wrap.

Test Plan:
Bench uses TIMEOUT_CYCLES=20, HOLD_CYCLES=4.
- Keys 1,2,3,4,5 on consecutive cycles -> cycle after 5th strobe: entry_valid=1, digit_a..e=1,2,3,4,5, digit_count=5 for 4 cycles; then entry_valid=0, all digits 4'hF, count 0.
- Keys 1,2,9, 0xE, 3,4,5 -> count sequence 1,2,3,2,3,4,5; presented code 1,2,3,4,5. 0xE in IDLE leaves count 0.
- Keys 1,2 then idle 19 cycles -> timeout pulse on exactly one cycle, count 0, state IDLE. Repeat with a key strobed on the expiry cycle -> no pulse, count 3.
- Keys 1,2,3, 0xF -> count 0 next cycle, no timeout pulse. Key 0xB in COLLECT -> count unchanged, timer not reloaded.
- During PRESENT strobe 7, 0xE, 0xF -> presented 1,2,3,4,5 unchanged for all 4 cycles.
- Assert rst asynchronously mid-PRESENT and mid-COLLECT -> entry_valid 0, digits 4'hF, count 0 without waiting for a clk edge.
